oric_sdram_bridge: RTL

//  Converts the Oric core's asynchronous-style byte RAM bus (cs/oe/we) into toggle req/ack

---
 rtl/oric_sdram_bridge.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/oric_sdram_bridge.sv
// ============================================================================
// Module   : oric_sdram_bridge
// Purpose  : Oric cs/oe/we byte RAM bus to toggle req/ack 16-bit SDRAM port.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module oric_sdram_bridge #(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_72,
    input  logic              reset,
    input  logic              ram_cs,
    input  logic              ram_oe,
    input  logic              ram_we,
    input  logic [ADDR_W-1:0] ram_ad,
    input  logic [7:0]        ram_d,
    output logic [7:0]        ram_q,
    output logic              port_req,
    input  logic              port_ack,
    output logic [ADDR_W-1:0] port_a,
    output logic [1:0]        port_ds,
    output logic              port_we,
    output logic [15:0]       port_d,
    input  logic [15:0]       port_q,
    output logic              busy,
    output logic              overrun,
    output logic              timeout
);

    localparam logic [1:0] S_SYNC  = 2'd0;
    localparam logic [1:0] S_IDLE  = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_ISSUE = 2'd3;
    localparam logic [7:0] CNT_MAX = 8'(TIMEOUT);

    logic              s_cs_q, s_oe_q, s_we_q, p_cs_q, p_oe_q, p_we_q;
    logic [ADDR_W-1:0] s_ad_q, p_ad_q;
    logic [7:0]        s_d_q;

    logic [1:0]        state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              pend_v_q, pend_v_d, pend_we_q, pend_we_d;
    logic [ADDR_W-1:0] pend_ad_q, pend_ad_d;
    logic [7:0]        pend_d_q, pend_d_d;
    logic              port_req_q, port_req_d, port_we_q, port_we_d;
    logic [ADDR_W-1:0] port_a_q, port_a_d;
    logic [1:0]        port_ds_q, port_ds_d;
    logic [15:0]       port_d_q, port_d_d;
    logic [7:0]        ram_q_q, ram_q_d;
    logic              overrun_q, overrun_d, timeout_q, timeout_d, busy_q, busy_d;

    logic              w_trig, w_match, w_issue, w_from_pend, w_pend_wr, w_src_we;
    logic [ADDR_W-1:0] w_src_ad;
    logic [7:0]        w_src_d;

    always_ff @(posedge clk_72 or posedge reset) begin
        if (reset) begin
            s_cs_q <= 1'b0;
            s_oe_q <= 1'b0;
            s_we_q <= 1'b0;
            s_ad_q <= '0;
            s_d_q  <= '0;
            p_cs_q <= 1'b0;
            p_oe_q <= 1'b0;
            p_we_q <= 1'b0;
            p_ad_q <= '0;
        end else begin
            s_cs_q <= ram_cs;
            s_oe_q <= ram_oe;
            s_we_q <= ram_we;
            s_ad_q <= ram_ad;
            s_d_q  <= ram_d;
            p_cs_q <= s_cs_q;
            p_oe_q <= s_oe_q;
            p_we_q <= s_we_q;
            p_ad_q <= s_ad_q;
        end
    end

    assign w_trig = (s_cs_q & s_oe_q & ~(p_cs_q & p_oe_q))
                  | (s_cs_q & s_we_q & ~(p_cs_q & p_we_q))
                  | (s_cs_q & s_oe_q & (s_ad_q != p_ad_q));
    assign w_match = (port_ack == port_req_q);
    // The slot is being drained this cycle in ISSUE, so it never blocks a new trig then.
    assign w_pend_wr = pend_v_q & pend_we_q & (state_q != S_ISSUE);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_v_d    = pend_v_q;
        pend_we_d   = pend_we_q;
        pend_ad_d   = pend_ad_q;
        pend_d_d    = pend_d_q;
        port_req_d  = port_req_q;
        port_we_d   = port_we_q;
        port_a_d    = port_a_q;
        port_ds_d   = port_ds_q;
        port_d_d    = port_d_q;
        ram_q_d     = ram_q_q;
        overrun_d   = overrun_q;
        timeout_d   = timeout_q;
        w_issue     = 1'b0;
        w_from_pend = 1'b0;

        case (state_q)
            S_SYNC: begin
                cnt_d = cnt_q + 8'd1;
                if (w_match) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    port_req_d = port_ack;
                    timeout_d  = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            S_IDLE: begin
                if (w_trig) begin
                    w_issue = 1'b1;
                end else if (pend_v_q) begin
                    w_issue     = 1'b1;
                    w_from_pend = 1'b1;
                    pend_v_d    = 1'b0;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (w_match) begin
                    if (!port_we_q) begin
                        ram_q_d = port_a_q[0] ? port_q[15:8] : port_q[7:0];
                    end
                    state_d = (pend_v_q | w_trig) ? S_ISSUE : S_IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    port_req_d = port_ack;
                    timeout_d  = 1'b1;
                    state_d    = (pend_v_q | w_trig) ? S_ISSUE : S_IDLE;
                end
            end
            default: begin
                w_issue     = 1'b1;
                w_from_pend = 1'b1;
                pend_v_d    = 1'b0;
            end
        endcase

        // A pending write is never displaced by a read; write-over-write is an overrun.
        if (w_trig && (state_q != S_IDLE)) begin
            if (!w_pend_wr || s_we_q) begin
                pend_v_d  = 1'b1;
                pend_we_d = s_we_q;
                pend_ad_d = s_ad_q;
                pend_d_d  = s_d_q;
                if (w_pend_wr) begin
                    overrun_d = 1'b1;
                end
            end
        end

        w_src_ad = w_from_pend ? pend_ad_q : s_ad_q;
        w_src_we = w_from_pend ? pend_we_q : s_we_q;
        w_src_d  = w_from_pend ? pend_d_q  : s_d_q;

        if (w_issue) begin
            port_a_d   = w_src_ad;
            port_we_d  = w_src_we;
            port_d_d   = {w_src_d, w_src_d};
            port_ds_d  = w_src_we ? (w_src_ad[0] ? 2'b10 : 2'b01) : 2'b11;
            port_req_d = ~port_req_q;
            cnt_d      = 8'd0;
            state_d    = S_WAIT;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_72 or posedge reset) begin
        if (reset) begin
            state_q    <= S_SYNC;
            cnt_q      <= '0;
            pend_v_q   <= 1'b0;
            pend_we_q  <= 1'b0;
            pend_ad_q  <= '0;
            pend_d_q   <= '0;
            port_req_q <= 1'b0;
            port_we_q  <= 1'b0;
            port_a_q   <= '0;
            port_ds_q  <= '0;
            port_d_q   <= '0;
            ram_q_q    <= '0;
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_v_q   <= pend_v_d;
            pend_we_q  <= pend_we_d;
            pend_ad_q  <= pend_ad_d;
            pend_d_q   <= pend_d_d;
            port_req_q <= port_req_d;
            port_we_q  <= port_we_d;
            port_a_q   <= port_a_d;
            port_ds_q  <= port_ds_d;
            port_d_q   <= port_d_d;
            ram_q_q    <= ram_q_d;
            overrun_q  <= overrun_d;
            timeout_q  <= timeout_d;
            busy_q     <= busy_d;
        end
    end

    assign ram_q    = ram_q_q;
    assign port_req = port_req_q;
    assign port_a   = port_a_q;
    assign port_ds  = port_ds_q;
    assign port_we  = port_we_q;
    assign port_d   = port_d_q;
    assign busy     = busy_q;
    assign overrun  = overrun_q;
    assign timeout  = timeout_q;

endmodule

`default_nettype wire
